ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decoder and consumes its ALU select/op pair plus two operands. Computes the result, owns the HI/LO special registers, and registers the outcome into the EX/MEM boundary. Honours pipeline stall and flush from the hazard/control unit.

---
 rtl/decode_table.sv | 47 ++++
 rtl/ex_stage_hilo.sv | 31 +++
 rtl/ex_stage.sv | 137 +++++++++++++
 tb/tb_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decode_table.sv
// Shared decode definitions for the execute stage and its neighbours.
//   alu_sel_t  : result-group select produced by the decoder
//   alu_op_t   : operation within a result group
//   ZERO_WORD  : all-zero datapath word
//   ex_mem_t   : EX/MEM pipeline register contents, also read by the mem stage
package decode_table;

  localparam int unsigned EX_DATA_W = 32;
  localparam int unsigned EX_ADDR_W = 5;

  localparam logic [EX_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    RES_NOP   = 3'b000,
    RES_LOGIC = 3'b001,
    RES_SHIFT = 3'b010,
    RES_MOVE  = 3'b011,
    RES_ARITH = 3'b100
  } alu_sel_t;

  typedef enum logic [7:0] {
    NOP_OP  = 8'b0000_0000,
    SRL_OP  = 8'b0000_0010,
    SRA_OP  = 8'b0000_0011,
    MOVZ_OP = 8'b0000_1010,
    MOVN_OP = 8'b0000_1011,
    MFHI_OP = 8'b0001_0000,
    MTHI_OP = 8'b0001_0001,
    MFLO_OP = 8'b0001_0010,
    MTLO_OP = 8'b0001_0011,
    ADD_OP  = 8'b0010_0000,
    AND_OP  = 8'b0010_0100,
    OR_OP   = 8'b0010_0101,
    XOR_OP  = 8'b0010_0110,
    NOR_OP  = 8'b0010_0111,
    LUI_OP  = 8'b0101_1100,
    SLL_OP  = 8'b0111_1100
  } alu_op_t;

  typedef struct packed {
    logic                 valid;
    logic                 wreg;
    logic [EX_ADDR_W-1:0] waddr;
    logic [EX_DATA_W-1:0] wdata;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_hilo.sv
// HI/LO special-register pair.
//   clk, rst        : clock, synchronous active-high reset (clears both)
//   stall           : hold both registers regardless of write enables
//   we_hi, we_lo    : write enables
//   wdata_hi/lo     : write data
//   hi, lo          : current register contents
module hilo_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata_hi,
  input  logic [DATA_W-1:0] wdata_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!stall) begin
      if (we_hi) hi <= wdata_hi;
      if (we_lo) lo <= wdata_lo;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
//   clk, rst           : clock, synchronous active-high reset
//   stall, flush       : hazard control (flush beats stall)
//   in_valid           : decoder slot holds a real instruction
//   alu_sel, alu_op    : result group and operation from the decoder
//   op_a, op_b         : operands (op_a carries shamt for shifts)
//   wreg_in, waddr_in  : GPR write request and destination
//   out_valid, wreg_out, waddr_out, wdata_out : EX/MEM register
//   hi_out, lo_out     : current HI/LO contents
module ex_stage
  import decode_table::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  alu_sel_t              alu_sel,
  input  alu_op_t               alu_op,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic                  wreg_in,
  input  logic [REG_ADDR_W-1:0] waddr_in,
  output logic                  out_valid,
  output logic                  wreg_out,
  output logic [REG_ADDR_W-1:0] waddr_out,
  output logic [DATA_W-1:0]     wdata_out,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic [DATA_W-1:0] result;
  logic              wreg_c;
  logic              is_mthi;
  logic              is_mtlo;
  logic              we_hi;
  logic              we_lo;
  ex_mem_t           ex_mem;

  always_comb begin
    result  = ZERO_WORD;
    wreg_c  = wreg_in;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (alu_sel)
      RES_LOGIC: begin
        case (alu_op)
          OR_OP:   result = op_a | op_b;
          AND_OP:  result = op_a & op_b;
          XOR_OP:  result = op_a ^ op_b;
          NOR_OP:  result = ~(op_a | op_b);
          LUI_OP:  result = {op_b[15:0], 16'h0000};
          default: wreg_c = 1'b0;
        endcase
      end
      RES_SHIFT: begin
        case (alu_op)
          SLL_OP:  result = op_b << op_a[4:0];
          SRL_OP:  result = op_b >> op_a[4:0];
          SRA_OP:  result = $signed(op_b) >>> op_a[4:0];
          default: wreg_c = 1'b0;
        endcase
      end
      RES_ARITH: begin
        case (alu_op)
          ADD_OP:  result = op_a + op_b;
          default: wreg_c = 1'b0;
        endcase
      end
      RES_MOVE: begin
        case (alu_op)
          MFHI_OP: result = hi_out;
          MFLO_OP: result = lo_out;
          MOVN_OP: begin
            result = op_a;
            wreg_c = wreg_in & (op_b != ZERO_WORD);
          end
          MOVZ_OP: begin
            result = op_a;
            wreg_c = wreg_in & (op_b == ZERO_WORD);
          end
          MTHI_OP: begin
            wreg_c  = 1'b0;
            is_mthi = 1'b1;
          end
          MTLO_OP: begin
            wreg_c  = 1'b0;
            is_mtlo = 1'b1;
          end
          default: wreg_c = 1'b0;
        endcase
      end
      default: wreg_c = 1'b0;
    endcase
  end

  // Stall gating lives in hilo_reg; flush suppresses the write here so a
  // flushed MTHI/MTLO never lands even when stall is also asserted.
  assign we_hi = in_valid & ~flush & is_mthi;
  assign we_lo = in_valid & ~flush & is_mtlo;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .we_hi    (we_hi),
    .we_lo    (we_lo),
    .wdata_hi (op_a),
    .wdata_lo (op_a),
    .hi       (hi_out),
    .lo       (lo_out)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_mem <= '0;
    end else if (!stall) begin
      if (in_valid) begin
        ex_mem.valid <= 1'b1;
        ex_mem.wreg  <= wreg_c;
        ex_mem.waddr <= waddr_in;
        ex_mem.wdata <= result;
      end else begin
        ex_mem <= '0;
      end
    end
  end

  assign out_valid = ex_mem.valid;
  assign wreg_out  = ex_mem.wreg;
  assign waddr_out = ex_mem.waddr;
  assign wdata_out = ex_mem.wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_ex_stage;
  import decode_table::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, wreg_in;
  alu_sel_t    alu_sel;
  alu_op_t     alu_op;
  logic [31:0] op_a, op_b;
  logic [4:0]  waddr_in;
  logic        out_valid, wreg_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out, hi_out, lo_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // model state
  logic        m_valid, m_wreg;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_hi, m_lo;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_sel(alu_sel), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .wreg_in(wreg_in), .waddr_in(waddr_in),
    .out_valid(out_valid), .wreg_out(wreg_out), .waddr_out(waddr_out),
    .wdata_out(wdata_out), .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Architectural meaning of one instruction, written from the ISA rules.
  task automatic ref_exec(input alu_sel_t s, input alu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic w, output logic [31:0] res,
                          output logic wr, output logic set_hi, output logic set_lo);
    int unsigned sh;
    sh = a % 32;
    res = 0; wr = 0; set_hi = 0; set_lo = 0;
    if (s == RES_LOGIC && o == OR_OP)       begin res = a | b;            wr = w; end
    else if (s == RES_LOGIC && o == AND_OP) begin res = a & b;            wr = w; end
    else if (s == RES_LOGIC && o == XOR_OP) begin res = a ^ b;            wr = w; end
    else if (s == RES_LOGIC && o == NOR_OP) begin res = ~a & ~b;          wr = w; end
    else if (s == RES_LOGIC && o == LUI_OP) begin res = b * 32'd65536;    wr = w; end
    else if (s == RES_SHIFT && o == SLL_OP) begin res = b * (64'd1 << sh); wr = w; end
    else if (s == RES_SHIFT && o == SRL_OP) begin res = b / (64'd1 << sh); wr = w; end
    else if (s == RES_SHIFT && o == SRA_OP) begin
      res = b / (64'd1 << sh);
      if (b[31]) res = res | ~(32'hFFFF_FFFF / (64'd1 << sh));
      wr = w;
    end
    else if (s == RES_ARITH && o == ADD_OP) begin res = a + b;           wr = w; end
    else if (s == RES_MOVE && o == MFHI_OP) begin res = m_hi;            wr = w; end
    else if (s == RES_MOVE && o == MFLO_OP) begin res = m_lo;            wr = w; end
    else if (s == RES_MOVE && o == MOVN_OP) begin res = a; wr = w && (b != 0); end
    else if (s == RES_MOVE && o == MOVZ_OP) begin res = a; wr = w && (b == 0); end
    else if (s == RES_MOVE && o == MTHI_OP) set_hi = 1;
    else if (s == RES_MOVE && o == MTLO_OP) set_lo = 1;
  endtask

  task automatic step();
    logic [31:0] res;
    logic        wr, sh_hi, sh_lo;
    @(posedge clk);
    ref_exec(alu_sel, alu_op, op_a, op_b, wreg_in, res, wr, sh_hi, sh_lo);
    if (rst) begin
      {m_valid, m_wreg, m_waddr, m_wdata, m_hi, m_lo} = '0;
    end else if (flush) begin
      {m_valid, m_wreg, m_waddr, m_wdata} = '0;
    end else if (!stall) begin
      if (in_valid) begin
        m_valid = 1; m_wreg = wr; m_waddr = waddr_in; m_wdata = res;
        if (sh_hi) m_hi = op_a;
        if (sh_lo) m_lo = op_a;
      end else begin
        {m_valid, m_wreg, m_waddr, m_wdata} = '0;
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("wreg_out",  32'(wreg_out),  32'(m_wreg));
    check_eq("waddr_out", 32'(waddr_out), 32'(m_waddr));
    check_eq("wdata_out", wdata_out, m_wdata);
    check_eq("hi_out",    hi_out, m_hi);
    check_eq("lo_out",    lo_out, m_lo);
  endtask

  task automatic drive(input logic v, input alu_sel_t s, input alu_op_t o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic w, input logic [4:0] ad);
    in_valid = v; alu_sel = s; alu_op = o; op_a = a; op_b = b;
    wreg_in = w; waddr_in = ad;
  endtask

  alu_sel_t sels[5] = '{RES_NOP, RES_LOGIC, RES_SHIFT, RES_MOVE, RES_ARITH};
  alu_op_t  ops[16] = '{NOP_OP, SRL_OP, SRA_OP, MOVZ_OP, MOVN_OP, MFHI_OP, MTHI_OP,
                        MFLO_OP, MTLO_OP, ADD_OP, AND_OP, OR_OP, XOR_OP, NOR_OP,
                        LUI_OP, SLL_OP};

  initial begin
    {m_valid, m_wreg, m_waddr, m_wdata, m_hi, m_lo} = '0;
    rst = 1; stall = 0; flush = 0;
    drive(0, RES_NOP, NOP_OP, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    step();
    check_eq("reset_wdata", wdata_out, 32'h0);

    drive(1, RES_ARITH, ADD_OP, 32'd5, 32'd7, 1, 5'd3);
    step();
    check_eq("add_wdata", wdata_out, 32'd12);
    check_eq("add_waddr", 32'(waddr_out), 32'd3);
    drive(1, RES_ARITH, ADD_OP, 32'hFFFF_FFFF, 32'd2, 1, 5'd4);
    step();
    check_eq("add_wrap", wdata_out, 32'd1);
    drive(1, RES_SHIFT, SRA_OP, 32'h24, 32'h8000_0000, 1, 5'd5);
    step();
    check_eq("sra", wdata_out, 32'hF800_0000);
    drive(1, RES_LOGIC, LUI_OP, 32'h0, 32'h1234, 1, 5'd6);
    step();
    check_eq("lui", wdata_out, 32'h1234_0000);

    drive(1, RES_MOVE, MTHI_OP, 32'hDEAD_BEEF, 32'h0, 1, 5'd7);
    step();
    check_eq("mthi_wreg", 32'(wreg_out), 32'd0);
    drive(1, RES_MOVE, MFHI_OP, 32'h0, 32'h0, 1, 5'd8);
    step();
    check_eq("mfhi_wdata", wdata_out, 32'hDEAD_BEEF);
    check_eq("mfhi_hi", hi_out, 32'hDEAD_BEEF);

    drive(1, RES_MOVE, MOVN_OP, 32'd9, 32'd0, 1, 5'd9);
    step();
    check_eq("movn_wreg", 32'(wreg_out), 32'd0);
    drive(1, RES_MOVE, MOVZ_OP, 32'd9, 32'd0, 1, 5'd10);
    step();
    check_eq("movz_wreg", 32'(wreg_out), 32'd1);
    check_eq("movz_wdata", wdata_out, 32'd9);

    drive(1, RES_LOGIC, alu_op_t'(8'hAA), 32'h1, 32'h2, 1, 5'd11);
    step();
    check_eq("unlisted_wreg", 32'(wreg_out), 32'd0);

    drive(1, RES_LOGIC, OR_OP, 32'hF000, 32'h00F0, 1, 5'd12);
    step();
    stall = 1;
    drive(1, RES_MOVE, MTLO_OP, 32'h5555, 32'h0, 1, 5'd13);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_hold", wdata_out, 32'h0000_F0F0);
      check_eq("stall_lo", lo_out, 32'h0);
    end

    flush = 1;
    drive(1, RES_MOVE, MTLO_OP, 32'h1, 32'h0, 1, 5'd14);
    step();
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_lo", lo_out, 32'h0);
    flush = 0; stall = 0;
    step();
    rst = 1; stall = 1;
    step();
    check_eq("rst_mid_hi", hi_out, 32'h0);
    rst = 0; stall = 0;

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 4) != 0), sels[$urandom_range(0, 4)],
            ($urandom_range(0, 15) == 0) ? alu_op_t'(8'($urandom())) : ops[$urandom_range(0, 15)],
            a, b, 1'($urandom()), 5'($urandom()));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
